// File: rtl/ram_responder.sv
// Word-addressed RAM-side responder for the cpu_ram_if protocol, with programmable latency and abort-on-change.
// Define RAM_RESPONDER_ERRCHK_EN to enable request error checking and the ERROR state.
module ram_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 16384
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

`ifdef RAM_RESPONDER_ERRCHK_EN
  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`endif

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
  } req_t;

  state_t      r_state, w_nstate;
  logic [3:0]  r_cnt, w_ncnt;
  req_t        r_req, w_nreq;
  req_t        w_req;
  logic        w_any;
  logic        w_do_acc;
  logic [IW-1:0] w_widx;
  logic [31:0] r_load;
  logic [31:0] r_mem [DEPTH];
  ramstate_t   w_rs;

  assign w_req  = '{ren: ramREN, wen: ramWEN, addr: ramaddr, store: ramstore};
  assign w_any  = ramREN | ramWEN;
  // Low index bits only: without error checking this gives the modulo-DEPTH wrap (DEPTH a power of two).
  assign w_widx = r_req.addr[IW+1:2];

`ifdef RAM_RESPONDER_ERRCHK_EN
  logic w_oob;
  logic w_err;
  assign w_oob = (ramaddr[31:2] >= 30'(DEPTH));
  assign w_err = w_any & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) | w_oob);
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
      r_load  <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_req   <= w_nreq;
      if (w_do_acc && !r_req.wen) r_load <= r_mem[w_widx];
    end
  end

  // REN&WEN together latches as a write when checking is compiled out.
  always_ff @(posedge CLK) begin
    if (w_do_acc && r_req.wen) r_mem[w_widx] <= r_req.store;
  end

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nreq   = r_req;
    w_do_acc = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef RAM_RESPONDER_ERRCHK_EN
        if (w_err) begin
          w_nstate = ERR;
        end else
`endif
        if (w_any) begin
          w_nstate = WAIT;
          w_nreq   = w_req;
          w_ncnt   = CNT_INIT;
        end
      end
      WAIT: begin
`ifdef RAM_RESPONDER_ERRCHK_EN
        if (w_err) begin
          w_nstate = ERR;
        end else
`endif
        if (w_req != r_req) begin
          if (w_any) begin
            w_nreq = w_req;
            w_ncnt = CNT_INIT;
          end else begin
            w_nstate = IDLE;
          end
        end else if (r_cnt != 4'd0) begin
          w_ncnt = r_cnt - 4'd1;
        end else begin
          w_do_acc = 1'b1;
          w_nstate = DONE;
        end
      end
      DONE: w_nstate = IDLE;
`ifdef RAM_RESPONDER_ERRCHK_EN
      ERR: if (!w_err) w_nstate = IDLE;
`endif
      default: w_nstate = IDLE;
    endcase
  end

  always_comb begin
    w_rs = FREE;
    case (r_state)
      IDLE: w_rs = FREE;
      WAIT: w_rs = BUSY;
      DONE: w_rs = ACCESS;
`ifdef RAM_RESPONDER_ERRCHK_EN
      ERR:  w_rs = ERROR;
`endif
      default: w_rs = FREE;
    endcase
  end

  assign ramstate = w_rs;
  assign ramload  = r_load;

endmodule
